fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage directly upstream of `branch_unit`. It owns the PC register and presents the PC to the BLT lookup. It steers next-PC from the prediction (`take_branch`/`branch_predict`) or from the redirect (`flush`/`jump_address`). It drives a 1-cycle-latency synchronous instruction memory and delivers instructions into the IF/ID register, together with the prediction that `branch_unit` later checks as `branch_taken`/`branch_taken_address`.

## Interface
Parameters: none. Widths come from global macros `ADDR_WIDTH`, `INST_WIDTH`, `NUM_PIPE_MASKS`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard unit holds IF/ID and PC.
- `flush` in `NUM_PIPE_MASKS`: from `branch_unit`. Only the `PIPE_REG_PC` and `PIPE_REG_IF_ID` bits are used.
- `jump_address` in `ADDR_WIDTH`: redirect target, valid when the `PIPE_REG_PC` bit is set.
- `pc` out `ADDR_WIDTH`: current PC register, driven to the BLT `read_key`.
- `take_branch` in 1: BLT hit for `pc`, combinational in the same cycle.
- `branch_predict` in `ADDR_WIDTH`: BLT predicted target for `pc`.
- `imem_addr` out `ADDR_WIDTH`: equals `pc`.
- `imem_data` in `INST_WIDTH`: returns `mem[imem_addr]` one cycle after the address is presented.
- `if_id_valid` out 1
- `if_id_pc` out `ADDR_WIDTH`
- `if_id_instruction` out `INST_WIDTH`
- `if_id_branch_taken` out 1: prediction made for this instruction.
- `if_id_branch_taken_address` out `ADDR_WIDTH`
- `fetch_count` out 32: instructions accepted into IF/ID.
- `redirect_count` out 32: `PIPE_REG_PC` flushes taken.

## Operation
Stages:
- **F1 (PC register):** presents `pc` to the BLT and to imem.
- **F2:** holds the in-flight request as `f2_valid`, `f2_pc`, `f2_taken`, `f2_target`.
- **IF/ID:** the output register.

Next-PC priority:
1. `reset`: PC becomes 0.
2. `flush[PIPE_REG_PC]`: PC becomes `jump_address`.
3. `stall`: PC holds.
4. `take_branch`: PC becomes `branch_predict`.
5. Otherwise: PC becomes `pc+1`, modulo 2^`ADDR_WIDTH` (all-ones wraps to 0).

F2 capture when advancing: `f2_valid`=1, `f2_pc`=`pc`, `f2_taken`=`take_branch`, and `f2_target`=`branch_predict` if taken, else `pc+1`.

Instruction source: `skid_valid ? skid_data : imem_data`.

Skid state machine (one entry):
- **RUN:** no skid entry held.
- **RUN → HELD:** when `stall && f2_valid && !flush[PC]`, capture `imem_data` into `skid_data`. Required because imem output changes once the address is re-presented.
- **HELD:** skid holds the data while the stall persists.
- **HELD → RUN:** on the first cycle with `!stall`. IF/ID loads from the skid, the skid clears, and F2 reloads from F1.
- **Flush:** `flush[PC]` in any state forces RUN and clears `skid_valid` and `f2_valid`.

IF/ID update:
- `flush[PIPE_REG_IF_ID]`: `if_id_valid` becomes 0.
- Else if `stall`: hold.
- Else: load from F2. `if_id_valid` = `f2_valid && !flush[PC]`.
- When `if_id_valid`=0, `if_id_instruction` is forced to `NOP_INSTRUCTION` and `if_id_branch_taken` to 0.

Counters:
- `fetch_count` increments on every IF/ID load with valid=1.
- `redirect_count` increments on every cycle with `flush[PC]`=1.
- Both wrap.

Edge cases:
- `flush[PC]` with `stall`: the flush wins. PC redirects and F2, skid and IF/ID (if its bit is set) are killed.
- `PIPE_REG_EX_MEM`-only flush (correctly predicted jump) has no effect here.
- `reset` asserted mid-stall or mid-redirect clears everything immediately (asynchronous).

## Timing
- Reset values: `pc`=0, `imem_addr`=0, all valids 0, `if_id_*`=0 (instruction = `NOP_INSTRUCTION`), counters 0, state RUN.
- Fetch latency: the instruction at PC p appears in IF/ID 2 cycles after `pc`=p (F1 → F2 → IF/ID) when there is no stall.
- Redirect: `flush[PC]` sampled at edge n puts `pc`=`jump_address` at cycle n+1. The first valid IF/ID from the target appears at cycle n+3.
- Steady throughput: one instruction per cycle, including predicted-taken branches (zero bubbles).
- Release after a stall: the held instruction enters IF/ID on the first unstalled edge, with no loss and no duplication.

## Structure
- The shared defines header carries `ADDR_WIDTH`, `INST_WIDTH`, `NUM_PIPE_MASKS`, the `PIPE_REG_*` masks and `NOP_INSTRUCTION`, plus new `FETCH_RUN` / `FETCH_HELD` state encodings.
- One sub-module, `fetch_skid`: the one-entry skid buffer with capture/release/clear and the source mux.
- The PC, F2 and IF/ID registers stay in `fetch_unit`.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → `pc`=0, `if_id_valid`=0, counters 0 before the next edge.
- **Sequential fetch:** mem[k]=k+0x100, no predictions → IF/ID shows pc 0,1,2… with instruction 0x100,0x101… from cycle 2 onward; `fetch_count` increments each cycle.
- **Predicted branch:** BLT hit at pc 4 → 20 → `pc` sequence 4,20,21. IF/ID for pc 4 has `branch_taken`=1, address 20. No bubble.
- **Redirect:** at pc 9, flush = `EX_MEM|ID_EX|IF_ID|PC` with `jump_address`=40 → `pc`=40 next cycle; instructions from 9/10 never reach IF/ID; first valid IF/ID is pc 40 at +3; `redirect_count`=1.
- **Stall with skid:** stall 3 cycles while F2 holds pc 6 → IF/ID holds. After release, pc 6 loads with mem[6]; pc 7 follows, with no duplicates.
- **Flush during stall and wrap:** stall plus flush to all-ones → stall is overridden and the skid is cleared. The next PC is 0 (wrap). The IF/ID sequence is 0xFF…F then 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, pipeline flush masks and fetch-stage types.
package fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH     = 8;
    localparam int unsigned INST_WIDTH     = 32;
    localparam int unsigned NUM_PIPE_MASKS = 4;

    // Bit positions inside the flush vector
    localparam int unsigned PIPE_REG_PC     = 0;
    localparam int unsigned PIPE_REG_IF_ID  = 1;
    localparam int unsigned PIPE_REG_ID_EX  = 2;
    localparam int unsigned PIPE_REG_EX_MEM = 3;

    localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HELD = 1'b1
    } fetch_state_e;

    // In-flight request between the PC register and IF/ID
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } f2_req_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: BLT lookup, instruction memory, redirect and IF/ID outputs.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                      stall;
    logic [NUM_PIPE_MASKS-1:0] flush;
    logic [ADDR_WIDTH-1:0]     jump_address;
    logic [ADDR_WIDTH-1:0]     pc;
    logic                      take_branch;
    logic [ADDR_WIDTH-1:0]     branch_predict;
    logic [ADDR_WIDTH-1:0]     imem_addr;
    logic [INST_WIDTH-1:0]     imem_data;
    logic                      if_id_valid;
    logic [ADDR_WIDTH-1:0]     if_id_pc;
    logic [INST_WIDTH-1:0]     if_id_instruction;
    logic                      if_id_branch_taken;
    logic [ADDR_WIDTH-1:0]     if_id_branch_taken_address;
    logic [31:0]               fetch_count;
    logic [31:0]               redirect_count;

    // Fetch unit side
    modport master (
        input  stall, flush, jump_address, take_branch, branch_predict, imem_data,
        output pc, imem_addr, if_id_valid, if_id_pc, if_id_instruction,
               if_id_branch_taken, if_id_branch_taken_address,
               fetch_count, redirect_count
    );

    // Pipeline / memory / BLT side
    modport slave (
        output stall, flush, jump_address, take_branch, branch_predict, imem_data,
        input  pc, imem_addr, if_id_valid, if_id_pc, if_id_instruction,
               if_id_branch_taken, if_id_branch_taken_address,
               fetch_count, redirect_count
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer: keeps the F2 instruction alive while the PC holds
// during a stall, since imem output moves on once the address is re-presented.
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_f2_valid,
    input  logic [INST_WIDTH-1:0] i_imem_data,
    output logic [INST_WIDTH-1:0] o_inst_c
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic                  w_capture;
    logic                  w_release;
    logic [INST_WIDTH-1:0] r_skid_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH_RUN;
        else     r_state <= w_state_next;
    end

    // Next state and capture/release strobes
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        if (i_flush) begin
            w_state_next = FETCH_RUN;
        end else begin
            case (r_state)
                FETCH_RUN: begin
                    if (i_stall && i_f2_valid) begin
                        w_state_next = FETCH_HELD;
                        w_capture    = 1'b1;
                    end
                end
                FETCH_HELD: begin
                    if (!i_stall) begin
                        w_state_next = FETCH_RUN;
                        w_release    = 1'b1;
                    end
                end
                default: w_state_next = FETCH_RUN;
            endcase
        end
    end

    // Skid data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_skid_data <= '0;
        else if (i_flush || w_release)  r_skid_data <= '0;
        else if (w_capture)             r_skid_data <= i_imem_data;
    end

    // Instruction source mux
    assign o_inst_c = (r_state == FETCH_HELD) ? r_skid_data : i_imem_data;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, F2 request register, IF/ID register
// and fetch/redirect counters.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    logic [ADDR_WIDTH-1:0] r_pc;
    f2_req_t               r_f2;
    logic                  r_if_id_valid;
    logic [ADDR_WIDTH-1:0] r_if_id_pc;
    logic [INST_WIDTH-1:0] r_if_id_instruction;
    logic                  r_if_id_taken;
    logic [ADDR_WIDTH-1:0] r_if_id_taken_address;
    logic [31:0]           r_fetch_count;
    logic [31:0]           r_redirect_count;

    logic                  w_flush_pc;
    logic                  w_flush_if_id;
    logic                  w_advance;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [INST_WIDTH-1:0] w_inst;
    logic                  w_load_valid;
    logic                  w_unused_flush;

    assign w_flush_pc     = bus.flush[PIPE_REG_PC];
    assign w_flush_if_id  = bus.flush[PIPE_REG_IF_ID];
    assign w_unused_flush = ^{bus.flush[PIPE_REG_ID_EX], bus.flush[PIPE_REG_EX_MEM]};
    assign w_advance      = !bus.stall && !w_flush_pc;
    assign w_pc_inc       = r_pc + ADDR_WIDTH'(1);
    assign w_load_valid   = r_f2.valid && !w_flush_pc;

    // Next-PC priority: redirect, stall, prediction, sequential
    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_flush_pc)            w_pc_next = bus.jump_address;
        else if (bus.stall)        w_pc_next = r_pc;
        else if (bus.take_branch)  w_pc_next = bus.branch_predict;
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pc <= '0;
        else       r_pc <= w_pc_next;
    end

    // F2 request register: killed by redirect, held by stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f2 <= '0;
        end else if (w_flush_pc) begin
            r_f2.valid <= 1'b0;
        end else if (w_advance) begin
            r_f2.valid  <= 1'b1;
            r_f2.pc     <= r_pc;
            r_f2.taken  <= bus.take_branch;
            r_f2.target <= bus.take_branch ? bus.branch_predict : w_pc_inc;
        end
    end

    fetch_skid u_skid (
        .clk         (clk),
        .rst         (reset),
        .i_stall     (bus.stall),
        .i_flush     (w_flush_pc),
        .i_f2_valid  (r_f2.valid),
        .i_imem_data (bus.imem_data),
        .o_inst_c    (w_inst)
    );

    // IF/ID register; invalid entries carry a NOP and no prediction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_id_valid         <= 1'b0;
            r_if_id_pc            <= '0;
            r_if_id_instruction   <= NOP_INSTRUCTION;
            r_if_id_taken         <= 1'b0;
            r_if_id_taken_address <= '0;
        end else if (w_flush_if_id) begin
            r_if_id_valid         <= 1'b0;
            r_if_id_instruction   <= NOP_INSTRUCTION;
            r_if_id_taken         <= 1'b0;
        end else if (!bus.stall) begin
            r_if_id_valid         <= w_load_valid;
            r_if_id_pc            <= r_f2.pc;
            r_if_id_instruction   <= w_load_valid ? w_inst : NOP_INSTRUCTION;
            r_if_id_taken         <= w_load_valid && r_f2.taken;
            r_if_id_taken_address <= r_f2.target;
        end
    end

    // Fetch and redirect counters (free-running, wrap)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count    <= '0;
            r_redirect_count <= '0;
        end else begin
            if (!w_flush_if_id && !bus.stall && w_load_valid)
                r_fetch_count <= r_fetch_count + 32'd1;
            if (w_flush_pc)
                r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign bus.pc                         = r_pc;
    assign bus.imem_addr                  = r_pc;
    assign bus.if_id_valid                = r_if_id_valid;
    assign bus.if_id_pc                   = r_if_id_pc;
    assign bus.if_id_instruction          = r_if_id_instruction;
    assign bus.if_id_branch_taken         = r_if_id_taken;
    assign bus.if_id_branch_taken_address = r_if_id_taken_address;
    assign bus.fetch_count                = r_fetch_count;
    assign bus.redirect_count             = r_redirect_count;

endmodule
